// File: rtl/riscv_decode_pkg.sv
// Shared opcode constants, decoded-class encoding and FIFO entry layout for the RV32 decode stage.
package riscv_decode_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        TYPE_NONE   = 4'd0,
        TYPE_R      = 4'd1,
        TYPE_I_ALU  = 4'd2,
        TYPE_LOAD   = 4'd3,
        TYPE_JALR   = 4'd4,
        TYPE_S      = 4'd5,
        TYPE_B      = 4'd6,
        TYPE_LUI    = 4'd7,
        TYPE_AUIPC  = 4'd8,
        TYPE_J      = 4'd9,
        TYPE_SYS    = 4'd10,
        TYPE_MULDIV = 4'd11
    } insn_type_t;

    // The immediate is XLEN-dependent, so it is queued alongside this entry rather than inside it.
    typedef struct packed {
        insn_type_t  insn_type;
        logic        illegal;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  shamt;
    } decode_t;

endpackage

// File: rtl/riscv_imm_gen.sv
// Per-format immediate extraction with sign extension from instruction bit 31 to XLEN (XLEN >= 32).
module riscv_imm_gen
    import riscv_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     insn_hi,
    input  logic [3:0]      insn_type,
    output logic [XLEN-1:0] imm
);

    logic signed [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (insn_type)
            TYPE_I_ALU, TYPE_LOAD, TYPE_JALR, TYPE_SYS:
                imm32 = {{20{insn_hi[31]}}, insn_hi[31:20]};
            TYPE_S:
                imm32 = {{20{insn_hi[31]}}, insn_hi[31:25], insn_hi[11:7]};
            TYPE_B:
                imm32 = {{20{insn_hi[31]}}, insn_hi[7], insn_hi[30:25], insn_hi[11:8], 1'b0};
            TYPE_LUI, TYPE_AUIPC:
                imm32 = {insn_hi[31:12], 12'b0};
            TYPE_J:
                imm32 = {{12{insn_hi[31]}}, insn_hi[19:12], insn_hi[20], insn_hi[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    assign imm = XLEN'(imm32);

endmodule

// File: rtl/riscv_decode_stage.sv
// RV32 decode stage: combinational decode of fetched words into a DEPTH-entry FIFO toward execute.
// Optional build macro RV32M_EN enables decoding of the M-extension (funct7=0000001) as TYPE_MULDIV.
module riscv_decode_stage
    import riscv_decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     imem_insn,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      destination_reg,
    output logic [4:0]      source_reg1,
    output logic [4:0]      source_reg2,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      shamt,
    output logic [XLEN-1:0] imm,
    output logic [3:0]      insn_type,
    output logic            illegal
);

    localparam int PTR_W = $clog2(DEPTH);

    insn_type_t      type_p0;
    logic            illegal_p0;
    decode_t         dec_p0;
    logic [XLEN-1:0] imm_p0;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             vld_p1;

    decode_t         fifo_mem [DEPTH];
    logic [XLEN-1:0] imm_mem  [DEPTH];
    decode_t         head_p1;

    // Stage p0: classify the opcode, then pick the fields that format actually carries.
    always_comb begin
        type_p0    = TYPE_NONE;
        illegal_p0 = 1'b0;
        case (imem_insn[6:0])
            OP: begin
                if (imem_insn[31:25] == F7_BASE || imem_insn[31:25] == F7_ALT) begin
                    type_p0 = TYPE_R;
                end
`ifdef RV32M_EN
                else if (imem_insn[31:25] == F7_MULDIV) begin
                    type_p0 = TYPE_MULDIV;
                end
`endif
                else begin
                    illegal_p0 = 1'b1;
                end
            end
            OP_IMM:  type_p0 = TYPE_I_ALU;
            LOAD:    type_p0 = TYPE_LOAD;
            JALR:    type_p0 = TYPE_JALR;
            STORE:   type_p0 = TYPE_S;
            BRANCH:  type_p0 = TYPE_B;
            LUI:     type_p0 = TYPE_LUI;
            AUIPC:   type_p0 = TYPE_AUIPC;
            JAL:     type_p0 = TYPE_J;
            SYSTEM:  type_p0 = TYPE_SYS;
            default: illegal_p0 = 1'b1;
        endcase
    end

    always_comb begin
        dec_p0           = '0;
        dec_p0.insn_type = type_p0;
        dec_p0.illegal   = illegal_p0;
        case (type_p0)
            TYPE_R, TYPE_MULDIV: begin
                dec_p0.rd     = imem_insn[11:7];
                dec_p0.rs1    = imem_insn[19:15];
                dec_p0.rs2    = imem_insn[24:20];
                dec_p0.funct3 = imem_insn[14:12];
                dec_p0.funct7 = imem_insn[31:25];
            end
            TYPE_I_ALU: begin
                dec_p0.rd     = imem_insn[11:7];
                dec_p0.rs1    = imem_insn[19:15];
                dec_p0.funct3 = imem_insn[14:12];
                // Only the shift-immediates reuse the upper immediate bits as shamt/funct7.
                if (imem_insn[13:12] == 2'b01) begin
                    dec_p0.shamt  = imem_insn[24:20];
                    dec_p0.funct7 = imem_insn[31:25];
                end
            end
            TYPE_LOAD, TYPE_JALR, TYPE_SYS: begin
                dec_p0.rd     = imem_insn[11:7];
                dec_p0.rs1    = imem_insn[19:15];
                dec_p0.funct3 = imem_insn[14:12];
            end
            TYPE_S, TYPE_B: begin
                dec_p0.rs1    = imem_insn[19:15];
                dec_p0.rs2    = imem_insn[24:20];
                dec_p0.funct3 = imem_insn[14:12];
            end
            TYPE_LUI, TYPE_AUIPC, TYPE_J: begin
                dec_p0.rd     = imem_insn[11:7];
            end
            default: ;
        endcase
    end

    riscv_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .insn_hi   (imem_insn[31:7]),
        .insn_type (type_p0),
        .imm       (imm_p0)
    );

    assign in_ready = (count != CNT_W'(DEPTH));
    assign vld_p1   = (count != '0);
    assign push     = in_valid && in_ready;
    assign pop      = vld_p1 && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Stage p1: FIFO storage; contents are only meaningful under count, so they carry no reset.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            fifo_mem[wr_ptr] <= dec_p0;
            imm_mem[wr_ptr]  <= imm_p0;
        end
    end

    assign head_p1         = fifo_mem[rd_ptr];
    assign out_valid       = vld_p1;
    assign destination_reg = vld_p1 ? head_p1.rd        : '0;
    assign source_reg1     = vld_p1 ? head_p1.rs1       : '0;
    assign source_reg2     = vld_p1 ? head_p1.rs2       : '0;
    assign funct3          = vld_p1 ? head_p1.funct3    : '0;
    assign funct7          = vld_p1 ? head_p1.funct7    : '0;
    assign shamt           = vld_p1 ? head_p1.shamt     : '0;
    assign imm             = vld_p1 ? imm_mem[rd_ptr]   : '0;
    assign insn_type       = vld_p1 ? head_p1.insn_type : TYPE_NONE;
    assign illegal         = vld_p1 ? head_p1.illegal   : 1'b0;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Bench for riscv_decode_stage: directed cases plus random traffic against a queue-based reference model.
module tb_riscv_decode_stage;

    localparam int DEPTH = 2;
`ifdef RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    localparam logic [3:0] T_NONE = 0, T_R = 1, T_I = 2, T_LD = 3, T_JALR = 4, T_S = 5,
                           T_B = 6, T_LUI = 7, T_AUIPC = 8, T_J = 9, T_SYS = 10, T_MD = 11;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready, illegal;
    logic [31:0] imem_insn, imm;
    logic [4:0]  destination_reg, source_reg1, source_reg2, shamt;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [3:0]  insn_type;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        ill;
        logic [3:0]  ty;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  sh;
        logic [31:0] imm;
    } exp_t;

    exp_t q[$];

    riscv_decode_stage #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .imem_insn(imem_insn),
        .out_valid(out_valid), .out_ready(out_ready),
        .destination_reg(destination_reg), .source_reg1(source_reg1), .source_reg2(source_reg2),
        .funct3(funct3), .funct7(funct7), .shamt(shamt), .imm(imm),
        .insn_type(insn_type), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference decode written from the ISA field rules with integer arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t e;
        int s, imm_i, imm_s, imm_b, imm_u, imm_j;
        e     = '0;
        s     = $signed(w);
        imm_i = s >>> 20;
        imm_s = ((s >>> 25) * 32) + int'(w[11:7]);
        imm_b = ((s >>> 31) * 4096) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        imm_u = s - int'(w[11:0]);
        imm_j = ((s >>> 31) * 1048576) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
        case (w[6:0])
            7'h33: begin
                if (w[31:25] == 7'h00 || w[31:25] == 7'h20) e.ty = T_R;
                else if (M_EN && w[31:25] == 7'h01)       e.ty = T_MD;
                else                                       e.ill = 1'b1;
                if (!e.ill) begin
                    e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.f3 = w[14:12]; e.f7 = w[31:25];
                end
            end
            7'h13: begin
                e.ty = T_I; e.rd = w[11:7]; e.rs1 = w[19:15]; e.f3 = w[14:12]; e.imm = imm_i;
                if (w[14:12] == 3'd1 || w[14:12] == 3'd5) begin
                    e.sh = w[24:20]; e.f7 = w[31:25];
                end
            end
            7'h03, 7'h67, 7'h73: begin
                e.ty  = (w[6:0] == 7'h03) ? T_LD : (w[6:0] == 7'h67) ? T_JALR : T_SYS;
                e.rd  = w[11:7]; e.rs1 = w[19:15]; e.f3 = w[14:12]; e.imm = imm_i;
            end
            7'h23: begin e.ty = T_S; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.f3 = w[14:12]; e.imm = imm_s; end
            7'h63: begin e.ty = T_B; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.f3 = w[14:12]; e.imm = imm_b; end
            7'h37: begin e.ty = T_LUI;   e.rd = w[11:7]; e.imm = imm_u; end
            7'h17: begin e.ty = T_AUIPC; e.rd = w[11:7]; e.imm = imm_u; end
            7'h6F: begin e.ty = T_J;     e.rd = w[11:7]; e.imm = imm_j; end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_insn();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 11))
            0: w[6:0] = 7'h33;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h03;  3: w[6:0] = 7'h67;
            4: w[6:0] = 7'h23;  5: w[6:0] = 7'h63;  6: w[6:0] = 7'h37;  7: w[6:0] = 7'h17;
            8: w[6:0] = 7'h6F;  9: w[6:0] = 7'h73;  10: w[6:0] = 7'h33;
            default: ;
        endcase
        if (w[6:0] == 7'h33) begin
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: ;
            endcase
        end
        return w;
    endfunction

    // One clock cycle: drive at edge+1, compare outputs mid-cycle, advance the model at the edge.
    task automatic cyc(input logic iv, input logic [31:0] w, input logic ordy, input logic fl);
        exp_t head;
        logic m_vld, m_rdy;
        in_valid  = iv;
        imem_insn = w;
        out_ready = ordy;
        flush     = fl;
        #4;
        m_vld = (q.size() != 0);
        m_rdy = (q.size() < DEPTH);
        head  = m_vld ? q[0] : '0;
        check("handshake", {out_valid, in_ready}, {m_vld, m_rdy});
        check("fields", {illegal, insn_type, destination_reg, source_reg1, source_reg2, funct3, funct7, shamt},
              {head.ill, head.ty, head.rd, head.rs1, head.rs2, head.f3, head.f7, head.sh});
        check("imm", imm, head.imm);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (m_vld && ordy) void'(q.pop_front());
            if (iv && m_rdy) q.push_back(ref_decode(w));
        end
        #1;
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_vld"}, out_valid, 0);
        check({tag, "_rdy"}, in_ready, 1);
        check({tag, "_flds"}, {illegal, insn_type, destination_reg, source_reg1, source_reg2,
                               funct3, funct7, shamt, imm}, 0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; imem_insn = '0;
        repeat (2) @(posedge clk);
        #1;
        check_empty("reset");
        reset = 1'b0;

        cyc(1, 32'hFFF10093, 0, 0);
        check("addi_vld", out_valid, 1);
        check("addi_rd", destination_reg, 1);
        check("addi_rs1", source_reg1, 2);
        check("addi_imm", imm, 32'hFFFFFFFF);
        check("addi_type", insn_type, T_I);
        check("addi_ill", illegal, 0);
        cyc(0, 0, 1, 0);

        cyc(1, 32'h00519193, 0, 0);
        check("slli_shamt", shamt, 5);
        check("slli_f3", funct3, 1);
        check("slli_f7", funct7, 0);
        check("slli_rd", destination_reg, 3);
        check("slli_rs1", source_reg1, 3);
        cyc(0, 0, 1, 0);

        cyc(1, 32'h00512423, 0, 0);
        check("sw_type", insn_type, T_S);
        check("sw_rs1", source_reg1, 2);
        check("sw_rs2", source_reg2, 5);
        check("sw_imm", imm, 8);
        check("sw_rd", destination_reg, 0);
        cyc(0, 0, 1, 0);

        // Backpressure: fill, hold a third word, then drain with overlapping push/pop.
        cyc(1, 32'hFFF10093, 0, 0);
        cyc(1, 32'h00519193, 0, 0);
        check("full_rdy", in_ready, 0);
        cyc(1, 32'h123453B7, 0, 0);
        check("full_head", destination_reg, 1);
        cyc(1, 32'h123453B7, 1, 0);
        check("pop1_head", destination_reg, 3);
        check("pop1_rdy", in_ready, 1);
        cyc(1, 32'h123453B7, 1, 0);
        check("pushpop_vld", out_valid, 1);
        check("pushpop_rdy", in_ready, 1);
        check("pushpop_rd", destination_reg, 7);
        check("pushpop_imm", imm, 32'h12345000);
        cyc(0, 0, 1, 0);
        check("drained_vld", out_valid, 0);

        cyc(1, 32'h023100B3, 0, 0);
`ifdef RV32M_EN
        check("mul_type", insn_type, T_MD);
        check("mul_ill", illegal, 0);
        check("mul_rs2", source_reg2, 3);
`else
        check("mul_type", insn_type, T_NONE);
        check("mul_ill", illegal, 1);
        check("mul_rs2", source_reg2, 0);
`endif
        cyc(0, 0, 1, 0);

        cyc(1, 32'hFFF10093, 0, 0);
        cyc(1, 32'h00519193, 0, 0);
        cyc(1, 32'h00512423, 0, 1);
        check_empty("flush_full");
        cyc(1, 32'hFFF10093, 0, 0);
        cyc(1, 32'h00519193, 1, 1);
        check_empty("flush_push");

        cyc(1, 32'hFFF10093, 0, 0);
        cyc(1, 32'h00519193, 0, 0);
        reset = 1'b1;
        #1;
        check_empty("midreset");
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;

        repeat (1500) begin
            cyc($urandom_range(0, 9) < 7, rand_insn(), $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
        end
        repeat (3) cyc(0, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
